// File: rtl/strobe_byte_drain.sv
// Buffers strobed AW-bit words in a small FIFO and drains them MSB-first as bytes over valid/ready.
// Optional build macro DROP_COUNT_EN adds a saturating drop counter and an 8'hFF marker byte after overflow.
module strobe_byte_drain #(
  parameter int AW         = 64,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] input_data,
  input  logic          input_enable,
  output logic [7:0]    byte_data,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          overflow,
  input  logic          overflow_clear,
  output logic          empty
`ifdef DROP_COUNT_EN
  ,
  output logic [15:0]   drop_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NB    = AW / 8;
  localparam int IDXW  = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [DEPTH_LOG2:0] PTR_ONE  = 1;
  localparam logic [IDXW-1:0]     IDX_ONE  = 1;
  localparam logic [IDXW-1:0]     IDX_LAST = IDXW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    MARK = 2'd2
  } state_t;

  state_t state, state_nxt;

  // FIFO storage and pointers; the extra MSB is the wrap bit.
  logic [AW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_addr, rd_addr;
  logic                  fifo_full, fifo_empty;
  logic                  push, drop, pop;

  logic [AW-1:0]   shift_reg;
  logic [IDXW-1:0] idx;
  logic            accept, last_byte;
  logic            load_mark, shift;
  logic            marker_pending;

  assign wr_addr    = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_addr    = rd_ptr[DEPTH_LOG2-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_addr == rd_addr) && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push = input_enable && (!fifo_full || pop);
  assign drop = input_enable && fifo_full && !pop;

  assign accept    = byte_valid && byte_ready;
  assign last_byte = (idx == IDX_LAST);

  assign byte_data = shift_reg[AW-1 -: 8];
  assign empty     = (state == IDLE) && fifo_empty;

  // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_addr] <= input_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

`ifdef DROP_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (overflow_clear) begin
      drop_count <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // Armed on the rising edge of overflow; consumed when the marker byte is loaded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      marker_pending <= 1'b0;
    end else begin
      if (load_mark)           marker_pending <= 1'b0;
      if (drop && !overflow)   marker_pending <= 1'b1;
    end
  end
`else
  assign marker_pending = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: each combinational block assigns defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = marker_pending ? MARK : SEND;
      end
      SEND: begin
        if (accept && last_byte) begin
          if (fifo_empty) state_nxt = IDLE;
          else            state_nxt = marker_pending ? MARK : SEND;
        end
      end
      MARK: begin
        if (accept) state_nxt = fifo_empty ? IDLE : SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pop always feeds a word into SEND; a marker is loaded instead of popping.
  always_comb begin
    pop       = 1'b0;
    load_mark = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: begin
        pop       = (state_nxt == SEND);
        load_mark = (state_nxt == MARK);
      end
      SEND: begin
        if (accept) begin
          if (last_byte) begin
            pop       = (state_nxt == SEND);
            load_mark = (state_nxt == MARK);
          end
          shift = !pop && !load_mark;
        end
      end
      MARK: begin
        if (accept) begin
          pop   = (state_nxt == SEND);
          shift = !pop;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      idx        <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= (state_nxt != IDLE);
      if (pop) begin
        shift_reg <= mem[rd_addr];
        idx       <= '0;
      end else if (load_mark) begin
        shift_reg            <= '0;
        shift_reg[AW-1 -: 8] <= 8'hFF;
        idx                  <= '0;
      end else if (shift) begin
        shift_reg <= shift_reg << 8;
        idx       <= idx + IDX_ONE;
      end
    end
  end

endmodule
